// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes, writer command kinds and writer state encodings.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] KIND_R    = 3'd0;
    localparam logic [2:0] KIND_LW   = 3'd1;
    localparam logic [2:0] KIND_SW   = 3'd2;
    localparam logic [2:0] KIND_BEQ  = 3'd3;
    localparam logic [2:0] KIND_ADDI = 3'd4;
    localparam logic [2:0] KIND_J    = 3'd5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: command kind plus fields to a 32-bit MIPS instruction word.
module instr_pack
    import mips_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        supported
);

    always_comb begin
        word      = '0;
        supported = 1'b1;
        case (kind)
            KIND_R:    word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            KIND_LW:   word = {OP_LW, rs, rt, imm};
            KIND_SW:   word = {OP_SW, rs, rt, imm};
            KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
            KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
            KIND_J:    word = {OP_J, target};
            default:   supported = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_mem_writer.sv
// Program loader: encodes commands and writes them sequentially into instruction memory.
// Optional readback check of every written word is enabled with MEM_VERIFY_EN.
module instr_mem_writer
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64,
    parameter int          CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_kind,
    input  logic [4:0]       cmd_rs,
    input  logic [4:0]       cmd_rt,
    input  logic [4:0]       cmd_rd,
    input  logic [4:0]       cmd_shamt,
    input  logic [5:0]       cmd_funct,
    input  logic [15:0]      cmd_imm,
    input  logic [25:0]      cmd_target,
    input  logic             finish,
    output logic             mem_we,
    output logic             mem_re,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] word_count,
    output logic             full,
    output logic             err_unsupported,
    output logic             verify_err,
    output logic             prog_done
);

    logic [2:0]       state;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      word_q;
    logic             finish_pend;
    logic             err_unsup_q;
    logic [31:0]      packed_word;
    logic             packed_ok;
    logic             handshake;

    instr_pack u_pack (
        .kind      (cmd_kind),
        .rs        (cmd_rs),
        .rt        (cmd_rt),
        .rd        (cmd_rd),
        .shamt     (cmd_shamt),
        .funct     (cmd_funct),
        .imm       (cmd_imm),
        .target    (cmd_target),
        .word      (packed_word),
        .supported (packed_ok)
    );

    always_comb begin
        full            = (count_q == CNT_W'(DEPTH));
        cmd_ready       = (state == ST_IDLE) && !full;
        handshake       = cmd_valid && cmd_ready;
        mem_we          = (state == ST_WRITE);
        mem_wdata       = mem_we ? word_q : '0;
        mem_addr        = addr_q;
        word_count      = count_q;
        err_unsupported = err_unsup_q;
        prog_done       = (state == ST_DONE);
    end

`ifdef MEM_VERIFY_EN
    logic verify_err_q;

    assign mem_re     = (state == ST_READ);
    assign verify_err = verify_err_q;
`else
    logic unused_rdata;

    assign mem_re       = 1'b0;
    assign verify_err   = 1'b0;
    assign unused_rdata = ^mem_rdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr_q      <= BASE_ADDR;
            count_q     <= '0;
            word_q      <= '0;
            finish_pend <= 1'b0;
            err_unsup_q <= 1'b0;
`ifdef MEM_VERIFY_EN
            verify_err_q <= 1'b0;
`endif
        end else begin
            if (finish && state != ST_DONE)
                finish_pend <= 1'b1;
            case (state)
                ST_IDLE: begin
                    // A command in the same cycle as finish wins; DONE waits for a quiet IDLE cycle.
                    if (handshake) begin
                        if (packed_ok) begin
                            word_q <= packed_word;
                            state  <= ST_WRITE;
                        end else begin
                            err_unsup_q <= 1'b1;
                        end
                    end else if (finish_pend || finish) begin
                        state <= ST_DONE;
                    end
                end
`ifdef MEM_VERIFY_EN
                ST_WRITE: state <= ST_READ;
                ST_READ:  state <= ST_CHECK;
                ST_CHECK: begin
                    if (mem_rdata != word_q)
                        verify_err_q <= 1'b1;
                    addr_q  <= addr_q + 32'd4;
                    count_q <= count_q + CNT_W'(1);
                    state   <= ST_IDLE;
                end
`else
                ST_WRITE: begin
                    addr_q  <= addr_q + 32'd4;
                    count_q <= count_q + CNT_W'(1);
                    state   <= ST_IDLE;
                end
`endif
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_writer.sv
// Directed bench for instr_mem_writer (DEPTH=4); adapts to MEM_VERIFY_EN builds.
module tb_instr_mem_writer;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef MEM_VERIFY_EN
    localparam int GAP = 4;
`else
    localparam int GAP = 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_kind;
    logic [4:0]       cmd_rs, cmd_rt, cmd_rd, cmd_shamt;
    logic [5:0]       cmd_funct;
    logic [15:0]      cmd_imm;
    logic [25:0]      cmd_target;
    logic             finish;
    logic             mem_we, mem_re;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [CNT_W-1:0] word_count;
    logic             full, err_unsupported, verify_err, prog_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic re_seen = 1'b0;
    logic flip = 1'b0;
    logic [31:0] mem [0:15];

    instr_mem_writer #(.BASE_ADDR(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_shamt(cmd_shamt), .cmd_funct(cmd_funct), .cmd_imm(cmd_imm),
        .cmd_target(cmd_target), .finish(finish), .mem_we(mem_we), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .word_count(word_count), .full(full), .err_unsupported(err_unsupported),
        .verify_err(verify_err), .prog_done(prog_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model; flip corrupts bit 0 on readback.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[5:2]] ^ {31'd0, flip};
    end

    always @(negedge clk) if (mem_re) re_seen <= 1'b1;

    task automatic clear_cmd();
        cmd_valid = 1'b0; finish = 1'b0;
        cmd_kind = 3'd0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
        cmd_shamt = '0; cmd_funct = '0; cmd_imm = '0; cmd_target = '0;
    endtask

    task automatic do_reset();
        clear_cmd();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                         input logic [15:0] imm, input logic [25:0] tg);
        cmd_kind = k; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_shamt = sh;
        cmd_funct = fn; cmd_imm = imm; cmd_target = tg; cmd_valid = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
        tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr got %h exp 00000000", mem_addr); end
        tests++; if (word_count !== 3'd0) begin fails++; $display("FAIL reset_word_count got %0d exp 0", word_count); end
        tests++;
        if ({mem_we, mem_re, full, err_unsupported, verify_err, prog_done} !== 6'b0) begin
            fails++; $display("FAIL reset_flags got %b exp 000000",
                              {mem_we, mem_re, full, err_unsupported, verify_err, prog_done});
        end
        tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h exp 00000000", mem_wdata); end
    endtask

    // Four words fill the DEPTH=4 block, then full/hold/finish behaviour.
    task automatic test_sequence_and_full();
        logic [2:0]  kinds [4] = '{3'd0, 3'd1, 3'd4, 3'd5};
        logic [4:0]  rss   [4] = '{5'd1, 5'd29, 5'd0, 5'd0};
        logic [4:0]  rts   [4] = '{5'd2, 5'd8, 5'd9, 5'd0};
        logic [15:0] imms  [4] = '{16'h0, 16'h0004, 16'hFFFF, 16'h0};
        logic [25:0] tgs   [4] = '{26'h0, 26'h0, 26'h0, 26'h10};
        logic [31:0] exp_w [4] = '{32'h00221820, 32'h8FA80004, 32'h2009FFFF, 32'h08000010};
        int we_cnt;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(kinds[i], rss[i], rts[i], 5'd3, 5'd0, 6'h20, imms[i], tgs[i]);
            tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL seq%0d_ready got %b exp 1", i, cmd_ready); end
            @(negedge clk);
            clear_cmd();
            tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL seq%0d_we got %b exp 1", i, mem_we); end
            tests++; if (mem_addr !== 32'(4 * i)) begin fails++; $display("FAIL seq%0d_addr got %h exp %h", i, mem_addr, 32'(4 * i)); end
            tests++; if (mem_wdata !== exp_w[i]) begin fails++; $display("FAIL seq%0d_wdata got %h exp %h", i, mem_wdata, exp_w[i]); end
            repeat (GAP - 1) @(negedge clk);
            tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL seq%0d_we_single got %b exp 0", i, mem_we); end
            tests++; if (word_count !== 3'(i + 1)) begin fails++; $display("FAIL seq%0d_count got %0d exp %0d", i, word_count, i + 1); end
        end
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL full_flag got %b exp 1", full); end
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b exp 0", cmd_ready); end
        tests++; if (verify_err !== 1'b0) begin fails++; $display("FAIL clean_verify_err got %b exp 0", verify_err); end
        we_cnt = 0;
        drive(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
        end
        clear_cmd();
        tests++; if (we_cnt != 0) begin fails++; $display("FAIL full_hold_writes got %0d exp 0", we_cnt); end
        tests++; if (word_count !== 3'd4) begin fails++; $display("FAIL full_hold_count got %0d exp 4", word_count); end
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        for (int k = 0; k < 8 && !prog_done; k++) @(negedge clk);
        tests++; if (prog_done !== 1'b1) begin fails++; $display("FAIL full_finish_done got %b exp 1", prog_done); end
        repeat (3) @(negedge clk);
        tests++; if ({prog_done, cmd_ready, mem_we} !== 3'b100) begin
            fails++; $display("FAIL done_hold got %b exp 100", {prog_done, cmd_ready, mem_we});
        end
    endtask

    task automatic test_unsupported();
        do_reset();
        drive(3'd6, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1);
        @(negedge clk);
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL unsup_no_write got %b exp 0", mem_we); end
        tests++; if (err_unsupported !== 1'b1) begin fails++; $display("FAIL unsup_flag got %b exp 1", err_unsupported); end
        tests++; if ({mem_addr, 29'd0, word_count} !== 64'h0) begin
            fails++; $display("FAIL unsup_state got addr %h count %0d exp 0/0", mem_addr, word_count);
        end
        drive(3'd2, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
        @(negedge clk);
        clear_cmd();
        tests++; if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hAC010000) begin
            fails++; $display("FAIL sw_after_unsup got we %b addr %h data %h exp 1 00000000 ac010000",
                              mem_we, mem_addr, mem_wdata);
        end
        repeat (GAP - 1) @(negedge clk);
        drive(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
        @(negedge clk);
        clear_cmd();
        @(negedge clk);
        tests++; if (word_count !== 3'd1 || mem_addr !== 32'h4) begin
            fails++; $display("FAIL kind7_state got count %0d addr %h exp 1 00000004", word_count, mem_addr);
        end
        tests++; if (err_unsupported !== 1'b1) begin fails++; $display("FAIL unsup_sticky got %b exp 1", err_unsupported); end
    endtask

    task automatic test_same_cycle_finish();
        do_reset();
        drive(3'd3, 5'd4, 5'd5, 5'd0, 5'd0, 6'h0, 16'hFFFE, 26'h0);
        finish = 1'b1;
        @(negedge clk);
        clear_cmd();
        tests++; if (mem_we !== 1'b1 || mem_wdata !== 32'h1085FFFE || prog_done !== 1'b0) begin
            fails++; $display("FAIL fin_cmd_write got we %b data %h done %b exp 1 1085fffe 0",
                              mem_we, mem_wdata, prog_done);
        end
        for (int k = 0; k < 8 && !prog_done; k++) @(negedge clk);
        tests++; if (prog_done !== 1'b1 || word_count !== 3'd1) begin
            fails++; $display("FAIL fin_done got done %b count %0d exp 1 1", prog_done, word_count);
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1, seen;
        do_reset();
        t0 = 0; t1 = 0; seen = 0;
        drive(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
        for (int k = 0; k < 20 && seen < 2; k++) begin
            @(negedge clk);
            if (mem_we) begin
                if (seen == 0) t0 = cyc; else t1 = cyc;
                seen++;
            end
        end
        clear_cmd();
        tests++; if (seen != 2 || (t1 - t0) != GAP) begin
            fails++; $display("FAIL b2b_spacing got %0d writes gap %0d exp 2 gap %0d", seen, t1 - t0, GAP);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        drive(3'd4, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1, 26'h0);
        @(negedge clk);
        clear_cmd();
        repeat (GAP - 1) @(negedge clk);
        drive(3'd4, 5'd2, 5'd2, 5'd0, 5'd0, 6'h0, 16'h2, 26'h0);
        @(negedge clk);
        clear_cmd();
        tests++; if (mem_we !== 1'b1 || mem_addr !== 32'h4) begin
            fails++; $display("FAIL rstw_setup got we %b addr %h exp 1 00000004", mem_we, mem_addr);
        end
        rst = 1'b1;
        #1;
        tests++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || word_count !== 3'd0) begin
            fails++; $display("FAIL rstw_async got we %b addr %h count %0d exp 0 00000000 0",
                              mem_we, mem_addr, word_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (cmd_ready !== 1'b1 || mem_we !== 1'b0) begin
            fails++; $display("FAIL rstw_idle got ready %b we %b exp 1 0", cmd_ready, mem_we);
        end
    endtask

    task automatic test_verify();
`ifdef MEM_VERIFY_EN
        int t_hs;
        do_reset();
        flip = 1'b1;
        drive(3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0);
        t_hs = cyc;
        @(negedge clk);
        clear_cmd();
        @(negedge clk);
        tests++; if (mem_re !== 1'b1 || (cyc - t_hs) != 2 || mem_addr !== 32'h0) begin
            fails++; $display("FAIL verify_re got re %b at +%0d addr %h exp 1 at +2 00000000",
                              mem_re, cyc - t_hs, mem_addr);
        end
        repeat (2) @(negedge clk);
        tests++; if (verify_err !== 1'b1) begin fails++; $display("FAIL verify_err got %b exp 1", verify_err); end
        flip = 1'b0;
`else
        tests++; if (re_seen !== 1'b0 || verify_err !== 1'b0) begin
            fails++; $display("FAIL noverify_tied got re_seen %b verr %b exp 0 0", re_seen, verify_err);
        end
`endif
    endtask

    initial begin
        mem_rdata = '0;
        clear_cmd();
        rst = 1'b1;
        test_reset();
        test_sequence_and_full();
        test_unsupported();
        test_same_cycle_finish();
        test_back_to_back();
        test_reset_mid_write();
        test_verify();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
